fifo_rd_serializer: RTL and testbench
=====================================

Name: fifo_rd_serializer

Overview:
- Read-domain consumer that drains the async FIFO's read side and transmits each word as a UART-style serial frame: start bit, data LSB first, optional parity, stop bit.
- Sits directly downstream of the FIFO. It watches empty, pulses rinc to pop, and captures r_data.
- Runs entirely in r_clk; no CDC inside.

Parameters:
- WIDTH, 8, data word width; must match the FIFO width.
- PRESCALE_W, 8, width of the prescale input.

Ports:
- r_clk  input  1  read-domain clock.
- r_rst  input  1  synchronous active-low reset; one clock (r_clk).
- empty  input  1  FIFO empty flag (r_clk domain).
- r_data  input  WIDTH  FIFO read data; valid combinationally while empty=0.
- rinc  output  1  pop strobe to FIFO, one cycle wide.
- par_en  input  1  1 = parity bit inserted.
- par_typ  input  1  0 = even, 1 = odd.
- prescale  input  PRESCALE_W  r_clk cycles per serial bit; 0 is treated as 1.
- tx_out  output  1  serial line, idle high.
- busy  output  1  high from the START state through the end of the last STOP cycle.

Behaviour:
- Reset (r_rst=0 sampled at a r_clk edge):
  - Outputs: tx_out=1, busy=0, rinc=0.
  - Internals: state=IDLE; bit counter, cycle counter, shift register and latched config all zero.
  - Reset mid-frame aborts the frame at that edge. The popped word is lost, and no extra pop occurs.
- rinc is combinational from state and empty:
  - rinc=1 only in IDLE with empty=0, or in the final cycle of STOP with empty=0.
  - rinc is never asserted while empty=1 and never asserted during reset.
- Pop capture: on the edge where rinc=1, latch r_data into the shift register. Latch par_en, par_typ and the effective prescale (max(prescale,1)) at the same edge; they stay fixed for the whole frame.
- Parity: computed at capture as XOR of the data bits, XOR par_typ.
- FSM states:
  - IDLE: tx_out=1, busy=0. Pop → START.
  - START: tx_out=0 for P cycles → DATA.
  - DATA: tx_out=shift[0] for P cycles per bit. Shift right after each bit. After WIDTH bits → PARITY if par_en, else STOP.
  - PARITY: tx_out=parity bit for P cycles → STOP.
  - STOP: tx_out=1 for P cycles. In the final cycle, pop if empty=0 and go to START; otherwise go to IDLE.
- Latency: the cycle after the pop edge shows tx_out=0, so start-bit latency is 1 r_clk from the rinc cycle.
- Frame length: (1 + WIDTH + par_en + 1) × P cycles.
- Back-to-back frames have no idle gap: the next start bit immediately follows the last stop cycle.
- Cycle counter runs 0..P-1 and wraps to 0 on each bit boundary. Bit counter runs 0..WIDTH-1. Both have enough width for the maximum values, with no overflow.
- empty deasserting mid-frame has no effect until the STOP final cycle.
- Changes on prescale, par_en or par_typ mid-frame are ignored until the next pop.
- All outputs are registered except rinc.

Decomposition:
- Package fifo_ser_pkg:
  - state enum (IDLE, START, DATA, PARITY, STOP) with 3-bit encoding;
  - constants IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1;
  - parity-type constants PAR_EVEN=0, PAR_ODD=1.
- One sub-module, fifo_ser_bit_timer:
  - inputs: load, effective prescale;
  - output: a one-cycle bit_done pulse on the final cycle of each bit period;
  - the FSM uses bit_done to advance.

Test Plan:
- Single word, no parity, prescale=1: FIFO holds 0xA1, empty falls.
  - rinc high for exactly 1 cycle.
  - tx_out sequence 0,1,0,0,0,0,1,0,1,1 over 10 cycles, then idle high; busy high for 10 cycles.
- Even parity, prescale=4, word 0xB2 (4 ones), par_typ=0: parity bit=0.
  - Frame is 44 cycles; each level is held exactly 4 cycles.
  - Repeat with par_typ=1: parity bit=1.
- Back-to-back: FIFO preloaded with 1,2,3, prescale=2, par_en=0.
  - Three rinc pulses spaced exactly 20 cycles apart.
  - No idle-high cycle between frames; after the third frame, state IDLE with rinc=0.
- Empty guard: empty held 1 for 100 cycles → rinc=0, tx_out=1, busy=0 throughout.
- Mid-frame reset: r_rst=0 during bit 3 of word 0xC3 with further data queued.
  - Next edge: tx_out=1, busy=0, rinc=0.
  - After release, the next pop occurs the first cycle empty=0, and the frame begins with a clean start bit.
- prescale=0 with word 0xD4 → behaves identically to prescale=1 (10-cycle frame); changing prescale to 5 mid-frame does not alter that frame's timing.

Source files
------------

// File: rtl/fifo_ser_pkg.sv
// Shared types and constants for the FIFO read-side serializer.
// Holds the frame FSM encoding, line levels and parity helpers.
package fifo_ser_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } ser_state_t;

   localparam logic IDLE_LEVEL  = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   // Turns the XOR-reduction of a word into the transmitted parity bit.
   function automatic logic parity_bit(input logic data_xor, input logic typ);
      logic res;
      case (typ)
         PAR_EVEN: res = data_xor;
         PAR_ODD:  res = ~data_xor;
         default:  res = data_xor;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/fifo_ser_bit_timer.sv
// Bit-period timer: counts 0..period-1 while a frame runs and flags the
// last cycle of every serial bit with a one-cycle bit_done pulse.
module fifo_ser_bit_timer #(
   parameter int PRESCALE_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load,
   input  logic                  run,
   input  logic [PRESCALE_W-1:0] period,
   output logic                  bit_done
);

   logic [PRESCALE_W-1:0] cnt;
   logic                  last;

   // period is never zero: the caller clamps it before latching.
   assign last     = (cnt == period - PRESCALE_W'(1));
   assign bit_done = run && last;

   always_ff @(posedge clk) begin
      if (!rst) begin
         cnt <= '0;
      end else if (load || !run || last) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PRESCALE_W'(1);
      end
   end

endmodule

// File: rtl/fifo_rd_serializer.sv
// Drains the async FIFO read side and sends each word as a UART-style frame:
// start bit, data LSB first, optional parity, stop bit, all in r_clk.
module fifo_rd_serializer
   import fifo_ser_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PRESCALE_W = 8
) (
   input  logic                  r_clk,
   input  logic                  r_rst,
   input  logic                  empty,
   input  logic [WIDTH-1:0]      r_data,
   output logic                  rinc,
   input  logic                  par_en,
   input  logic                  par_typ,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tx_out,
   output logic                  busy
);

   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   ser_state_t            state;
   logic [WIDTH-1:0]      shift_q;
   logic [WIDTH-1:0]      shift_nxt;
   logic [BIT_W-1:0]      bit_cnt;
   logic                  par_q;
   logic                  par_en_q;
   logic [PRESCALE_W-1:0] prescale_q;
   logic [PRESCALE_W-1:0] eff_prescale;
   logic                  bit_done;
   logic                  in_frame;

   assign eff_prescale = (prescale == '0) ? PRESCALE_W'(1) : prescale;
   assign in_frame     = (state != IDLE);
   assign shift_nxt    = shift_q >> 1;

   // Pops happen only when the line is free: idle, or the last stop cycle
   // so the next start bit follows with no gap.
   assign rinc = r_rst && !empty &&
                 ((state == IDLE) || ((state == STOP) && bit_done));

   fifo_ser_bit_timer #(
      .PRESCALE_W (PRESCALE_W)
   ) u_bit_timer (
      .clk      (r_clk),
      .rst      (r_rst),
      .load     (rinc),
      .run      (in_frame),
      .period   (prescale_q),
      .bit_done (bit_done)
   );

   always_ff @(posedge r_clk) begin
      if (!r_rst) begin
         state      <= IDLE;
         shift_q    <= '0;
         bit_cnt    <= '0;
         par_q      <= 1'b0;
         par_en_q   <= 1'b0;
         prescale_q <= '0;
         tx_out     <= IDLE_LEVEL;
         busy       <= 1'b0;
      end else begin
         // Frame configuration is frozen at the pop edge.
         if (rinc) begin
            shift_q    <= r_data;
            par_q      <= parity_bit(^r_data, par_typ);
            par_en_q   <= par_en;
            prescale_q <= eff_prescale;
         end

         case (state)
            IDLE: begin
               if (rinc) begin
                  state  <= START;
                  tx_out <= START_LEVEL;
                  busy   <= 1'b1;
               end
            end

            START: begin
               if (bit_done) begin
                  state   <= DATA;
                  bit_cnt <= '0;
                  tx_out  <= shift_q[0];
               end
            end

            DATA: begin
               if (bit_done) begin
                  if (bit_cnt == BIT_W'(WIDTH - 1)) begin
                     bit_cnt <= '0;
                     if (par_en_q) begin
                        state  <= PARITY;
                        tx_out <= par_q;
                     end else begin
                        state  <= STOP;
                        tx_out <= STOP_LEVEL;
                     end
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     shift_q <= shift_nxt;
                     tx_out  <= shift_nxt[0];
                  end
               end
            end

            PARITY: begin
               if (bit_done) begin
                  state  <= STOP;
                  tx_out <= STOP_LEVEL;
               end
            end

            STOP: begin
               if (bit_done) begin
                  if (rinc) begin
                     state  <= START;
                     tx_out <= START_LEVEL;
                  end else begin
                     state  <= IDLE;
                     tx_out <= IDLE_LEVEL;
                     busy   <= 1'b0;
                  end
               end
            end

            default: begin
               state  <= IDLE;
               tx_out <= IDLE_LEVEL;
               busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_serializer.sv
// Bench for fifo_rd_serializer: a small FIFO model feeds words, and each
// transmitted frame is compared against an independently built waveform.
module tb_fifo_rd_serializer;

   localparam int WIDTH      = 8;
   localparam int PRESCALE_W = 8;

   logic                  r_clk = 1'b0;
   logic                  r_rst = 1'b0;
   logic                  empty;
   logic [WIDTH-1:0]      r_data;
   logic                  rinc;
   logic                  par_en = 1'b0;
   logic                  par_typ = 1'b0;
   logic [PRESCALE_W-1:0] prescale = 8'd1;
   logic                  tx_out;
   logic                  busy;

   // clock / reset
   always #5 r_clk = ~r_clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   fifo_rd_serializer #(
      .WIDTH      (WIDTH),
      .PRESCALE_W (PRESCALE_W)
   ) dut (
      .r_clk    (r_clk),
      .r_rst    (r_rst),
      .empty    (empty),
      .r_data   (r_data),
      .rinc     (rinc),
      .par_en   (par_en),
      .par_typ  (par_typ),
      .prescale (prescale),
      .tx_out   (tx_out),
      .busy     (busy)
   );

   // FIFO model: show-ahead data, popped on the rinc edge
   logic [WIDTH-1:0] fifo_mem [0:15];
   int               wr_ptr = 0;
   int               rd_ptr = 0;
   logic             hold_empty = 1'b0;

   assign empty  = hold_empty || (wr_ptr == rd_ptr);
   assign r_data = fifo_mem[rd_ptr & 15];

   always @(posedge r_clk) begin
      if (rinc) rd_ptr <= rd_ptr + 1;
   end

   // scoreboard
   logic [WIDTH-1:0] exp_q[$];
   int               n_checks = 0;
   int               n_pass   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // driver tasks
   task automatic push_word(input logic [WIDTH-1:0] w);
      fifo_mem[wr_ptr & 15] = w;
      wr_ptr++;
      exp_q.push_back(w);
   endtask

   task automatic wait_pop(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 200; i++) begin
         #1;
         if (rinc) begin
            seen = 1'b1;
            break;
         end
         @(negedge r_clk);
      end
      check({tag, "_pop_seen"}, 64'(seen), 64'd1);
   endtask

   // Called right after the pop cycle; samples every cycle of the frame.
   task automatic frame_check(input string tag, input int p, input bit pe, input bit pt,
                              input bit expect_next, input int ps_change_at,
                              input logic [PRESCALE_W-1:0] ps_new);
      logic [WIDTH-1:0] w;
      logic             lv [0:WIDTH+2];
      logic [63:0]      exp_v, obs_v, obs_b, ones;
      int               nlev, len, idx, rinc_cnt;
      bit               last_rinc;
      if (exp_q.size() == 0) begin
         check({tag, "_exp_q"}, 64'd0, 64'd1);
         return;
      end
      w = exp_q.pop_front();
      nlev = 0;
      lv[nlev++] = 1'b0;
      for (int b = 0; b < WIDTH; b++) lv[nlev++] = w[b];
      if (pe) lv[nlev++] = (^w) ^ pt;
      lv[nlev++] = 1'b1;
      len = nlev * p;
      exp_v = '0;
      idx = 0;
      for (int k = 0; k < nlev; k++)
         for (int c = 0; c < p; c++) exp_v[idx++] = lv[k];
      ones = (64'd1 << len) - 64'd1;
      obs_v = '0;
      obs_b = '0;
      rinc_cnt = 0;
      last_rinc = 1'b0;
      for (int i = 0; i < len; i++) begin
         @(negedge r_clk);
         obs_v[i] = tx_out;
         obs_b[i] = busy;
         last_rinc = rinc;
         if (rinc) rinc_cnt++;
         if (i == ps_change_at) prescale = ps_new;
      end
      check({tag, "_tx"}, obs_v, exp_v);
      check({tag, "_busy"}, obs_b, ones);
      check({tag, "_rinc_cnt"}, 64'(rinc_cnt), 64'(expect_next));
      check({tag, "_rinc_last"}, 64'(last_rinc), 64'(expect_next));
      if (!expect_next) begin
         @(negedge r_clk);
         check({tag, "_idle_tx"}, 64'(tx_out), 64'd1);
         check({tag, "_idle_busy"}, 64'(busy), 64'd0);
         check({tag, "_idle_rinc"}, 64'(rinc), 64'd0);
      end
   endtask

   initial begin
      int bad;
      int ps;
      bit rpe, rpt;

      // reset with a word already waiting: no pop while in reset
      repeat (3) @(negedge r_clk);
      prescale = 8'd1;
      push_word(8'hA1);
      #1;
      check("rst_tx", 64'(tx_out), 64'd1);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_rinc", 64'(rinc), 64'd0);
      @(negedge r_clk);
      r_rst = 1'b1;

      // single word, no parity, prescale 1
      wait_pop("a1");
      frame_check("a1", 1, 1'b0, 1'b0, 1'b0, -1, 8'd0);

      // parity, prescale 4, even then odd
      par_en = 1'b1;
      prescale = 8'd4;
      par_typ = 1'b0;
      push_word(8'hB2);
      wait_pop("b2_even");
      frame_check("b2_even", 4, 1'b1, 1'b0, 1'b0, -1, 8'd0);
      par_typ = 1'b1;
      push_word(8'hB2);
      wait_pop("b2_odd");
      frame_check("b2_odd", 4, 1'b1, 1'b1, 1'b0, -1, 8'd0);

      // back-to-back frames from a preloaded FIFO
      par_en = 1'b0;
      par_typ = 1'b0;
      prescale = 8'd2;
      hold_empty = 1'b1;
      push_word(8'h01);
      push_word(8'h02);
      push_word(8'h03);
      hold_empty = 1'b0;
      wait_pop("b2b");
      frame_check("b2b_1", 2, 1'b0, 1'b0, 1'b1, -1, 8'd0);
      frame_check("b2b_2", 2, 1'b0, 1'b0, 1'b1, -1, 8'd0);
      frame_check("b2b_3", 2, 1'b0, 1'b0, 1'b0, -1, 8'd0);

      // empty guard
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge r_clk);
         if (rinc !== 1'b0 || tx_out !== 1'b1 || busy !== 1'b0) bad++;
      end
      check("empty_guard", 64'(bad), 64'd0);

      // reset during data bit 3 with another word queued
      hold_empty = 1'b1;
      push_word(8'hC3);
      push_word(8'h55);
      hold_empty = 1'b0;
      wait_pop("mr");
      repeat (9) @(negedge r_clk);
      check("mr_bit3", 64'(tx_out), 64'd0);
      r_rst = 1'b0;
      #1;
      check("mr_rst_rinc", 64'(rinc), 64'd0);
      @(negedge r_clk);
      check("mr_tx", 64'(tx_out), 64'd1);
      check("mr_busy", 64'(busy), 64'd0);
      check("mr_rinc", 64'(rinc), 64'd0);
      void'(exp_q.pop_front());
      r_rst = 1'b1;
      #1;
      check("mr_first_pop", 64'(rinc), 64'd1);
      frame_check("mr_55", 2, 1'b0, 1'b0, 1'b0, -1, 8'd0);

      // prescale 0 acts as 1; a mid-frame change must not stretch the frame
      prescale = 8'd0;
      push_word(8'hD4);
      wait_pop("d4");
      frame_check("d4", 1, 1'b0, 1'b0, 1'b0, 3, 8'd5);

      // random words and configurations
      for (int n = 0; n < 4; n++) begin
         ps = $urandom_range(0, 3);
         rpe = 1'($urandom_range(0, 1));
         rpt = 1'($urandom_range(0, 1));
         prescale = 8'(ps);
         par_en = rpe;
         par_typ = rpt;
         push_word(8'($urandom_range(0, 255)));
         wait_pop("rnd");
         frame_check("rnd", (ps == 0) ? 1 : ps, rpe, rpt, 1'b0, -1, 8'd0);
      end

      check("exp_q_drained", 64'(exp_q.size()), 64'd0);

      // final report
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
